// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 port responder: command codes,
// response codes and the controller state encoding.
package calc1_pkg;

  // Command codes presented on req_cmd_in
  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  // Response codes driven on out_resp
  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_OVF  = 2'd2;
  localparam logic [1:0] RESP_INV  = 2'd3;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPND2 = 2'd1,
    S_EXEC  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/calc1_alu.sv
// Combinational arithmetic for the calc1 responder.
// Shift commands exist only when CALC1_SHIFT_EN is defined; otherwise
// they fall through to the invalid-command response.
module calc1_alu
  import calc1_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        resp
);

  logic [DATA_W:0] sum_ext;

  assign sum_ext = {1'b0, op1} + {1'b0, op2};

`ifdef CALC1_SHIFT_EN
  logic [4:0] shamt;

  assign shamt = op2[4:0];
`endif

  // Result and response selection; any error response carries zero data
  always_comb begin
    result = '0;
    resp   = RESP_INV;
    case (cmd)
      CMD_ADD: begin
        if (sum_ext[DATA_W]) begin
          resp = RESP_OVF;
        end else begin
          resp   = RESP_OK;
          result = sum_ext[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (op2 > op1) begin
          resp = RESP_OVF;
        end else begin
          resp   = RESP_OK;
          result = op1 - op2;
        end
      end
`ifdef CALC1_SHIFT_EN
      CMD_SHL: begin
        resp   = RESP_OK;
        result = op1 << shamt;
      end
      CMD_SHR: begin
        resp   = RESP_OK;
        result = op1 >> shamt;
      end
`endif
      default: begin
        resp   = RESP_INV;
        result = '0;
      end
    endcase
  end

endmodule

// File: rtl/calc1_port_responder.sv
// Two-beat command port with a fixed-latency single-cycle response.
// Operand 1 arrives with the command, operand 2 on the following cycle;
// the response appears RESP_LAT cycles after operand 2 is captured.
// Optional feature macro: CALC1_SHIFT_EN (enables shift commands 5/6).
module calc1_port_responder
  import calc1_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RESP_LAT = 3
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req_cmd_in,
  input  logic [DATA_W-1:0] req_data_in,
  output logic [1:0]        out_resp,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [3:0] LAT_M1 = 4'(RESP_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cmd_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [DATA_W-1:0] alu_result;
  logic [1:0]        alu_resp;

  calc1_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .cmd   (cmd_q),
    .op1   (op1_q),
    .op2   (op2_q),
    .result(alu_result),
    .resp  (alu_resp)
  );

  // Next-state decode; commands are only looked at while idle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_cmd_in != CMD_NOP) state_nxt = S_OPND2;
      S_OPND2: state_nxt = S_EXEC;
      S_EXEC:  if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge c_clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command and operand capture
  always_ff @(posedge c_clk) begin
    if (reset) begin
      cmd_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
    end else begin
      if (state == S_IDLE && req_cmd_in != CMD_NOP) begin
        cmd_q <= req_cmd_in;
        op1_q <= req_data_in;
      end
      if (state == S_OPND2) begin
        op2_q <= req_data_in;
      end
    end
  end

  // Latency counter: loaded on operand-2 capture, counts down in EXEC
  always_ff @(posedge c_clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == S_OPND2) begin
      cnt <= LAT_M1;
    end else if (state == S_EXEC && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response register: loaded at the end of EXEC, cleared after one cycle
  always_ff @(posedge c_clk) begin
    if (reset) begin
      out_resp <= RESP_NONE;
      out_data <= '0;
    end else if (state == S_EXEC && cnt == 4'd0) begin
      out_resp <= alu_resp;
      out_data <= alu_result;
    end else begin
      out_resp <= RESP_NONE;
      out_data <= '0;
    end
  end

endmodule

// File: tb/tb_calc1_port_responder.sv
// Directed-vector bench for calc1_port_responder (RESP_LAT = 3).
module tb_calc1_port_responder;

  localparam int DATA_W   = 32;
  localparam int RESP_LAT = 3;

  logic              c_clk;
  logic              reset;
  logic [3:0]        req_cmd_in;
  logic [DATA_W-1:0] req_data_in;
  logic [1:0]        out_resp;
  logic [DATA_W-1:0] out_data;

  int checks;
  int failures;

  calc1_port_responder #(
    .DATA_W  (DATA_W),
    .RESP_LAT(RESP_LAT)
  ) dut (
    .c_clk      (c_clk),
    .reset      (reset),
    .req_cmd_in (req_cmd_in),
    .req_data_in(req_data_in),
    .out_resp   (out_resp),
    .out_data   (out_data)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Watch for any response over n cycles; used after ignored commands/aborts
  task automatic expect_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge c_clk);
      check($sformatf("%s_quiet%0d_resp", tag, i), 32'(out_resp), 32'd0);
      check($sformatf("%s_quiet%0d_data", tag, i), out_data, 32'd0);
    end
  endtask

  // Issue one command, check zero before, the response exactly at
  // edge T+1+RESP_LAT, and zero on the following cycle.
  // If late_cmd is set, a second command is driven during EXEC (k==2),
  // and another at the response cycle so it lands on the RESP->IDLE edge.
  task automatic run_op(input string tag, input logic [3:0] cmd,
                        input logic [31:0] op1, input logic [31:0] op2,
                        input logic [1:0] exp_resp, input logic [31:0] exp_data,
                        input bit late_cmd);
    @(negedge c_clk);
    req_cmd_in  = cmd;
    req_data_in = op1;
    @(negedge c_clk);          // edge T has passed
    req_cmd_in  = 4'd0;
    req_data_in = op2;
    for (int k = 1; k <= RESP_LAT + 2; k++) begin
      @(negedge c_clk);        // edge T+k has passed
      req_cmd_in  = 4'd0;
      req_data_in = '0;
      if (late_cmd && (k == 2 || k == RESP_LAT + 1)) begin
        req_cmd_in  = 4'd1;
        req_data_in = 32'h0000_0100;
      end
      if (k == RESP_LAT + 1) begin
        check({tag, "_resp"}, 32'(out_resp), 32'(exp_resp));
        check({tag, "_data"}, out_data, exp_data);
      end else begin
        check($sformatf("%s_idle%0d_resp", tag, k), 32'(out_resp), 32'd0);
        check($sformatf("%s_idle%0d_data", tag, k), out_data, 32'd0);
      end
    end
    req_cmd_in  = 4'd0;
    req_data_in = '0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    req_cmd_in  = 4'd1;        // present during reset; must be ignored
    req_data_in = 32'h0000_0055;
    repeat (3) @(negedge c_clk);
    check("rst_resp", 32'(out_resp), 32'd0);
    check("rst_data", out_data, 32'd0);
    req_cmd_in  = 4'd0;
    req_data_in = '0;
    reset       = 1'b0;
    expect_quiet("post_rst", 3);

    run_op("add_basic", 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000, 1'b0);
    run_op("add_carry", 4'd1, 32'hF000_0000, 32'hF000_0000, 2'd2, 32'h0000_0000, 1'b0);
    run_op("add_max",   4'd1, 32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF, 1'b0);
    run_op("add_wrap",  4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000, 1'b0);
    run_op("sub_under", 4'd2, 32'd5, 32'd7, 2'd2, 32'd0, 1'b0);
    run_op("sub_pos",   4'd2, 32'd7, 32'd5, 2'd1, 32'd2, 1'b0);
    run_op("sub_zero",  4'd2, 32'd5, 32'd5, 2'd1, 32'd0, 1'b0);
`ifdef CALC1_SHIFT_EN
    run_op("shl",       4'd5, 32'h0000_0001, 32'h0000_0024, 2'd1, 32'h0000_0010, 1'b0);
    run_op("shr",       4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001, 1'b0);
`else
    run_op("shl_off",   4'd5, 32'h0000_0001, 32'h0000_0024, 2'd3, 32'h0000_0000, 1'b0);
    run_op("shr_off",   4'd6, 32'h8000_0000, 32'h0000_001F, 2'd3, 32'h0000_0000, 1'b0);
`endif
    run_op("cmd3_inv",  4'd3, 32'd9, 32'd9, 2'd3, 32'd0, 1'b0);
    run_op("cmd15_inv", 4'd15, 32'd1, 32'd1, 2'd3, 32'd0, 1'b0);

    // Commands during EXEC and on the RESP->IDLE edge are dropped
    run_op("add_busy",  4'd1, 32'd2, 32'd3, 2'd1, 32'd5, 1'b1);
    expect_quiet("busy", RESP_LAT + 4);
    run_op("add_after", 4'd1, 32'd10, 32'd20, 2'd1, 32'd30, 1'b0);

    // Reset during EXEC aborts the operation
    @(negedge c_clk);
    req_cmd_in  = 4'd1;
    req_data_in = 32'd1;
    @(negedge c_clk);
    req_cmd_in  = 4'd0;
    req_data_in = 32'd1;
    @(negedge c_clk);          // OPND2 -> EXEC edge passed
    req_data_in = '0;
    check("abort_exec_resp", 32'(out_resp), 32'd0);
    reset       = 1'b1;
    req_cmd_in  = 4'd2;        // coincident with reset; must be ignored
    req_data_in = 32'd9;
    @(negedge c_clk);
    check("abort_rst_resp", 32'(out_resp), 32'd0);
    check("abort_rst_data", out_data, 32'd0);
    reset       = 1'b0;
    req_cmd_in  = 4'd0;
    req_data_in = '0;
    expect_quiet("abort", RESP_LAT + 4);
    run_op("add_post_abort", 4'd1, 32'd1, 32'd1, 2'd1, 32'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc1_port_responder.md
CALC1_PORT_RESPONDER -- requirements
Module: calc1_port_responder

Interface
REQ-001 SHALL have parameter DATA_W, 32, operand and result width.
REQ-002 SHALL have parameter RESP_LAT, 3, number of cycles from operand-2 capture to response (legal range 1..15).
REQ-003 SHALL have port c_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_cmd_in, input, 4, command code: 0 no-op, 1 add, 2 subtract, 5 shift left, 6 shift right; all others invalid.
REQ-006 SHALL have port req_data_in, input, DATA_W, operand 1 in the command cycle and operand 2 in the following cycle.
REQ-007 SHALL have port out_resp, output, 2, response code: 0 none, 1 success, 2 overflow/underflow, 3 invalid command.
REQ-008 SHALL have port out_data, output, DATA_W, result; valid only while out_resp is non-zero.

Function
REQ-009 SHALL implement the FSM IDLE -> OPND2 -> EXEC -> RESP -> IDLE.
REQ-010 In IDLE, a non-zero req_cmd_in at a clock edge SHALL latch the command and operand 1, then move to OPND2.
REQ-011 In OPND2, the next edge SHALL latch operand 2 regardless of req_cmd_in, load the latency counter with RESP_LAT-1, and move to EXEC.
REQ-012 In EXEC, the counter SHALL decrement each cycle; at 0 the block SHALL register the result and move to RESP.
REQ-013 For a command sampled at edge T, out_resp SHALL be non-zero for exactly one cycle, beginning just after edge T+1+RESP_LAT.
REQ-014 Add: out_data SHALL be op1+op2 modulo 2^DATA_W; a carry-out SHALL give resp 2 and out_data 0.
REQ-015 Subtract: out_data SHALL be op1-op2; op2>op1 SHALL give resp 2 and out_data 0.
REQ-016 Shifts SHALL be logical, with amount op2[4:0] (low 5 bits); bits shifted out are discarded with no overflow; resp 1.
REQ-017 An invalid command SHALL still consume the operand-2 cycle and latency, then give resp 3 and out_data 0.
REQ-018 A non-zero req_cmd_in outside IDLE SHALL be ignored; no queueing.
REQ-019 A command arriving in the same cycle that RESP returns to IDLE SHALL be ignored; it is only accepted once the FSM is in IDLE.
REQ-020 Whenever out_resp is 0, out_data SHALL be 0.

Reset
REQ-021 While reset is high at an edge, the FSM SHALL go to IDLE, the counter and latches SHALL clear, and out_resp and out_data SHALL become 0.
REQ-022 Reset during any state SHALL abort the operation; no response SHALL be emitted for it.
REQ-023 Commands present in the same cycle as reset SHALL be ignored.

Configuration
REQ-024 Macro CALC1_SHIFT_EN defined: commands 5 and 6 SHALL execute per REQ-016.
REQ-025 Macro CALC1_SHIFT_EN undefined: commands 5 and 6 SHALL be treated as invalid (resp 3), and no shifter logic SHALL be synthesised.

Structure
REQ-026 Package calc1_pkg SHALL hold the command codes (CMD_NOP, CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR), the response codes (RESP_NONE, RESP_OK, RESP_OVF, RESP_INV), and the FSM state enum.
REQ-027 The arithmetic SHALL be a combinational sub-module calc1_alu, taking cmd, op1 and op2 and returning result and resp; the FSM and latency counter stay in the top module.

Verification
REQ-028 The bench SHALL cover add 0x00000001 + 0x1FFFFFFF -> resp 1, data 0x20000000, exactly RESP_LAT+1 cycles after the cmd edge, one cycle wide.
REQ-029 The bench SHALL cover add 0xF0000000 + 0xF0000000 -> resp 2, data 0; and subtract 5-7 -> resp 2, data 0; and subtract 7-5 -> resp 1, data 2.
REQ-030 The bench SHALL cover shift left 0x00000001 by 0x00000024 (amount 4) -> resp 1, data 0x00000010; with CALC1_SHIFT_EN undefined the same stimulus -> resp 3, data 0.
REQ-031 The bench SHALL cover cmd 3 with operands 9 and 9 -> resp 3, data 0, at normal latency.
REQ-032 The bench SHALL cover a second add issued during EXEC -> ignored: only one response is produced, then a new add after return to IDLE -> correct response.
REQ-033 The bench SHALL cover reset asserted during EXEC of add 1+1 -> out_resp stays 0 throughout, with all outputs 0 on the cycle after the reset edge.
